// File: rtl/core_pkg.sv
// Shared core types for the memory-port arbiter and its helpers.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        LS_BUSY
    } arb_state_t;

    localparam logic [3:0] MEM_BE_FULL = 4'hF;

endpackage

// File: rtl/arb_fair_counter.sv
// Saturating run counter with synchronous clear; clear takes priority over increment.
module arb_fair_counter #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic nrst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAXV)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAXV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and the LSU: one outstanding
// transaction, LSU priority, fetch forced through after MAX_LS_RUN LSU grants.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_LS_RUN = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_mem,
    output logic              arb_eqmem,
    output logic              memOp_done
);

    arb_state_t        state_q, state_d;
    logic              drop_q, drop_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              done_q, done_d;
    logic              run_inc, run_clr, run_sat;

    arb_fair_counter #(
        .MAX(MAX_LS_RUN)
    ) u_fair (
        .clk  (clk),
        .nrst (nrst),
        .inc_i(run_inc),
        .clr_i(run_clr),
        .sat_o(run_sat)
    );

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_valid_d  = 1'b0;
        done_d      = 1'b0;
        run_inc     = 1'b0;
        run_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ls_req && (!if_req || !run_sat)) begin
                    state_d     = LS_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_be_d    = ls_be;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                end else if (if_req && !if_flush) begin
                    state_d    = IF_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = MEM_BE_FULL;
                    mem_addr_d = if_addr;
                end
            end
            IF_BUSY: begin
                if (if_flush) drop_d = 1'b1;
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    run_clr   = 1'b1;
                    // A flush arriving on the ack cycle itself still discards the word.
                    if (!drop_q && !if_flush) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            LS_BUSY: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    ls_rdata_d = mem_rdata;
                    done_d     = 1'b1;
                    run_inc    = if_req;
                    run_clr    = !if_req;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_valid_q  <= if_valid_d;
            done_q      <= done_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign if_valid   = if_valid_q;
    assign ls_rdata   = ls_rdata_q;
    assign memOp_done = done_q;
    assign arb_eqmem  = (state_q == LS_BUSY);
    assign stall_mem  = if_req && !((state_q == IF_BUSY) && mem_ack && !drop_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected bus transactions and read
// data are queued at stimulus time and checked as the DUT produces them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        if_req, if_flush, ls_req, ls_we, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_be;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic        if_valid, mem_req, mem_we, stall_mem, arb_eqmem, memOp_done;
    logic [3:0]  mem_be;

    typedef struct {
        bit          is_ls;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] if_q[$];
    logic [31:0] ls_q[$];
    bus_t        cur;
    bit          cur_valid = 1'b0;
    bit          prev_req  = 1'b0;
    int          ack_dly   = 1;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    logic [31:0] last_ls;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_LS_RUN(4)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_mem (stall_mem),
        .arb_eqmem (arb_eqmem),
        .memOp_done(memOp_done)
    );

    function automatic logic [31:0] resp(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_bus(input bit is_ls, input bit we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd, input bit chk_wd);
        bus_t t;
        t.is_ls = is_ls; t.we = we; t.be = be; t.addr = addr; t.wdata = wd; t.chk_wd = chk_wd;
        bus_q.push_back(t);
    endtask

    // Waits for if_valid (want_if) or memOp_done; ls_rdata must hold until an LSU ack.
    task automatic wait_evt(input bit want_if, input int lim, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk); #1;
            seen = want_if ? if_valid : memOp_done;
            if (!seen) chk({tag, "_ls_hold"}, ls_rdata, last_ls);
        end
        chk({tag, "_seen"}, 32'(seen), 32'(1'b1));
    endtask

    // Memory model: acks ack_dly cycles after mem_req is first seen.
    initial begin
        int cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!nrst || mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_req) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = resp(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Bus and read-data monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                chk("req_queued", 32'(bus_q.size() > 0), 32'(1'b1));
                if (bus_q.size() > 0) begin
                    cur = bus_q.pop_front();
                    cur_valid = 1'b1;
                    chk("req_we", 32'(mem_we), 32'(cur.we));
                    chk("req_be", 32'(mem_be), 32'(cur.be));
                    chk("req_addr", mem_addr, cur.addr);
                    chk("req_eqmem", 32'(arb_eqmem), 32'(cur.is_ls));
                    if (cur.chk_wd) chk("req_wdata", mem_wdata, cur.wdata);
                end
            end else if (mem_req && cur_valid) begin
                chk("hold_we", 32'(mem_we), 32'(cur.we));
                chk("hold_be", 32'(mem_be), 32'(cur.be));
                chk("hold_addr", mem_addr, cur.addr);
                chk("hold_eqmem", 32'(arb_eqmem), 32'(cur.is_ls));
            end
            if (if_valid) begin
                chk("ifv_queued", 32'(if_q.size() > 0), 32'(1'b1));
                if (if_q.size() > 0) chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (memOp_done) begin
                chk("done_queued", 32'(ls_q.size() > 0), 32'(1'b1));
                if (ls_q.size() > 0) chk("ls_rdata", ls_rdata, ls_q.pop_front());
            end
            prev_req = mem_req;
        end
    end

    initial begin
        int  dones;
        bit  got_if;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
        last_ls = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ifv", 32'(if_valid), 0);
        chk("rst_ifrd", if_rdata, 0);
        chk("rst_lsrd", ls_rdata, 0);
        chk("rst_done", 32'(memOp_done), 0);
        chk("rst_eqmem", 32'(arb_eqmem), 0);
        chk("rst_stall", 32'(stall_mem), 0);
        @(negedge clk);
        nrst = 1'b1;

        // Fetch, ack 3 cycles after request
        ack_dly = 3;
        push_bus(1'b0, 1'b0, 4'hF, 32'h100, '0, 1'b0);
        if_q.push_back(32'h13);
        if_addr = 32'h100; if_req = 1'b1;
        #1 chk("t1_stall_idle", 32'(stall_mem), 1);
        wait_evt(1'b1, 20, "t1");
        if_req = 1'b0;

        // Partial store
        ack_dly = 2;
        push_bus(1'b1, 1'b1, 4'b0011, 32'h2000, 32'hAABBCCDD, 1'b1);
        ls_q.push_back(resp(32'h2000));
        ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h2000; ls_wdata = 32'hAABBCCDD; ls_req = 1'b1;
        wait_evt(1'b0, 20, "t2");
        ls_req = 1'b0;
        last_ls = resp(32'h2000);
        @(negedge clk); #1;
        chk("t2_done_pulse", 32'(memOp_done), 0);
        chk("t2_eqmem_off", 32'(arb_eqmem), 0);

        // Fairness: 4 LSU grants, 1 fetch, then LSU again
        ack_dly = 1;
        repeat (4) begin
            push_bus(1'b1, 1'b0, 4'hF, 32'h3000, 32'h11112222, 1'b1);
            ls_q.push_back(resp(32'h3000));
        end
        push_bus(1'b0, 1'b0, 4'hF, 32'h400, '0, 1'b0);
        if_q.push_back(resp(32'h400));
        push_bus(1'b1, 1'b0, 4'hF, 32'h3000, 32'h11112222, 1'b1);
        ls_q.push_back(resp(32'h3000));
        ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h3000; ls_wdata = 32'h11112222;
        if_addr = 32'h400;
        ls_req = 1'b1; if_req = 1'b1;
        dones = 0; got_if = 1'b0;
        for (int i = 0; i < 60 && dones < 5; i++) begin
            @(negedge clk); #1;
            chk("t3_stall", 32'(stall_mem), 32'(if_req && !(mem_ack && !cur.is_ls)));
            if (if_valid) begin
                if_req = 1'b0;
                got_if = 1'b1;
            end
            if (memOp_done) begin
                dones++;
                if (dones == 5) ls_req = 1'b0;
            end
        end
        chk("t3_dones", dones, 5);
        chk("t3_fetch", 32'(got_if), 32'(1'b1));
        last_ls = resp(32'h3000);

        // Flush of an in-flight fetch, then a normal fetch
        ack_dly = 4;
        push_bus(1'b0, 1'b0, 4'hF, 32'h180, '0, 1'b0);
        push_bus(1'b0, 1'b0, 4'hF, 32'h200, '0, 1'b0);
        if_q.push_back(resp(32'h200));
        if_addr = 32'h180; if_req = 1'b1;
        @(negedge clk); #1;
        chk("t4_busy", 32'(mem_req), 1);
        if_flush = 1'b1; if_addr = 32'h200;
        @(negedge clk); #1;
        if_flush = 1'b0;
        wait_evt(1'b1, 30, "t4");
        if_req = 1'b0;

        // Slow load: bus stable and ls_rdata held for 10 cycles
        ack_dly = 10;
        push_bus(1'b1, 1'b0, 4'hF, 32'h2400, 32'h55AA00FF, 1'b1);
        ls_q.push_back(resp(32'h2400));
        ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h2400; ls_wdata = 32'h55AA00FF; ls_req = 1'b1;
        wait_evt(1'b0, 30, "t5");
        ls_req = 1'b0;
        last_ls = resp(32'h2400);

        // Reset while the LSU owns the port
        ack_dly = 20;
        push_bus(1'b1, 1'b0, 4'hF, 32'h2800, 32'h55AA00FF, 1'b1);
        ls_addr = 32'h2800; ls_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_pre_req", 32'(mem_req), 1);
        nrst = 1'b0; ls_req = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req), 0);
        chk("t6_eqmem", 32'(arb_eqmem), 0);
        chk("t6_done", 32'(memOp_done), 0);
        chk("t6_lsrd", ls_rdata, 0);
        last_ls = '0;
        @(negedge clk);
        nrst = 1'b1;

        ack_dly = 2;
        push_bus(1'b0, 1'b0, 4'hF, 32'h300, '0, 1'b0);
        if_q.push_back(resp(32'h300));
        if_addr = 32'h300; if_req = 1'b1;
        wait_evt(1'b1, 20, "t7");
        if_req = 1'b0;
        push_bus(1'b1, 1'b0, 4'hF, 32'h2800, 32'h55AA00FF, 1'b1);
        ls_q.push_back(resp(32'h2800));
        ls_req = 1'b1;
        wait_evt(1'b0, 20, "t8");
        ls_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        chk("bus_q_empty", bus_q.size(), 0);
        chk("if_q_empty", if_q.size(), 0);
        chk("ls_q_empty", ls_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the load/store unit (LSU).
- Sits between the frontend/execute stages and the memory interface.
- Generates the decode-stage hold signals stall_mem, arb_eqmem and memOp_done.
- Allows one outstanding transaction; LSU has priority; a fairness counter bounds fetch starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_LS_RUN, 4, consecutive LSU grants allowed while fetch waits before fetch is forced a grant (≥1)

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard an in-flight fetch (branch, jump or exception)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle pulse; if_rdata is valid
- ls_req  in  1  LSU request, level, held until memOp_done
- ls_we  in  1  1 = store
- ls_be  in  4  byte enables
- ls_addr  in  ADDR_W  LSU address
- ls_wdata  in  DATA_W  store data
- ls_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  memory completion, one-cycle pulse
- stall_mem  out  1  fetch is requesting but not being served this cycle
- arb_eqmem  out  1  LSU currently owns the port
- memOp_done  out  1  one-cycle pulse; LSU transaction complete

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=IDLE, ls_run=0, drop_pending=0.
  - mem_req, mem_we, if_valid, memOp_done and arb_eqmem are 0.
  - mem_be, mem_addr, mem_wdata, if_rdata and ls_rdata are 0.
- States: IDLE, IF_BUSY, LS_BUSY.
- IDLE grant decision, registered; mem_req asserts the cycle after the request is seen:
  - ls_req and (if_req=0 or ls_run<MAX_LS_RUN) -> LS_BUSY; latch ls_we, ls_be, ls_addr, ls_wdata into the mem_* registers.
  - Otherwise if_req and not if_flush -> IF_BUSY; latch if_addr; mem_we=0; mem_be=4'hF.
  - Neither -> stay IDLE.
- Busy states:
  - mem_req stays 1 and the mem_* registers stay stable until mem_ack.
  - On mem_ack: mem_req=0 and state -> IDLE in the same edge, so there is at least one idle cycle between transactions.
  - Minimum request-to-response latency is 2 cycles.
- LS_BUSY, on mem_ack:
  - ls_rdata <= mem_rdata.
  - memOp_done=1 for one cycle.
  - ls_run increments, saturating at MAX_LS_RUN, when if_req=1; otherwise ls_run clears.
- IF_BUSY, on mem_ack:
  - if_rdata <= mem_rdata and if_valid=1 for one cycle, unless drop_pending or if_flush is set that cycle.
  - ls_run clears.
- Flush:
  - if_flush while IF_BUSY sets drop_pending; the transaction still completes on the bus with no if_valid.
  - drop_pending clears on mem_ack.
  - if_flush in IDLE blocks a fetch grant that cycle only.
- arb_eqmem = (state==LS_BUSY), registered.
- stall_mem = if_req and not (state==IF_BUSY and mem_ack and not drop_pending); combinational.
- Simultaneous if_req and ls_req in IDLE: LSU wins unless ls_run==MAX_LS_RUN.
- A request deasserting while busy is a protocol violation; the transaction completes regardless.
- mem_ack outside a busy state is ignored.
- Reset mid-transaction: mem_req drops immediately; the memory side must tolerate abandonment.

Decomposition:
- Shared package core_pkg:
  - arb_state_t enum {IDLE, IF_BUSY, LS_BUSY}
  - MEM_BE_FULL = 4'hF
- Optional sub-module arb_fair_counter (saturating run counter with clear).
- The FSM and the registered mem_* signals stay in the top module.

Test Plan:
- Reset, then if_req=1, if_addr=0x100; mem_ack 3 cycles after mem_req with mem_rdata=0x00000013 -> mem_addr=0x100, mem_we=0, if_valid pulse, if_rdata=0x13, arb_eqmem stays 0.
- Store ls_req, ls_we=1, ls_be=4'b0011, ls_addr=0x2000, ls_wdata=0xAABBCCDD -> mem_be=0011, mem_wdata=0xAABBCCDD, arb_eqmem=1 until ack, memOp_done single pulse.
- if_req and ls_req both held, MAX_LS_RUN=4, mem_ack one cycle after each mem_req -> 4 LSU grants, then 1 fetch grant, then LSU again; stall_mem=1 throughout except the fetch-ack cycle.
- Fetch in flight, if_flush pulsed before mem_ack -> mem_ack consumed, no if_valid; next fetch to 0x200 returns normally.
- Load with mem_ack delayed 10 cycles -> mem_addr, mem_be and mem_we stable all 10 cycles; ls_rdata updates only at ack.
- nrst asserted while LS_BUSY -> mem_req=0 and arb_eqmem=0 asynchronously; no memOp_done; normal operation after release.
